game_state_ctrl: RTL

- Top-level game sequencer that sits directly upstream of the frog movement block.
- Produces the 2-bit `state` that gates frog movement, plus a one-cycle `respawn` pulse that the top level ORs into the frog block's collision/reset input.
- Consumes the collision and goal indications derived from the frog position; tracks lives, round timer, score and level.
- All timing is counted in frame ticks (one pulse per video frame).

---
 rtl/game_state_ctrl.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/game_state_ctrl.sv
// Game sequencer: MENU/PLAYING/DEAD/WIN with lives, round timer, score, level and respawn pulse.
// Latency: every output is registered and responds on the clk edge after the sampled input.
// Backpressure: none; inputs are level/pulse indications and are never stalled. Optional hiscore via GAME_HISCORE_EN.
module game_state_ctrl #(
   parameter int LIVES_INIT   = 3,
   parameter int DEAD_FRAMES  = 60,
   parameter int WIN_FRAMES   = 90,
   parameter int ROUND_FRAMES = 1800,
   parameter int GOAL_POINTS  = 10,
   parameter int SCORE_W      = 10,
   parameter int BLOCK_SHIFT  = 5
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               frame_tick,
   input  logic               start_tick,
   input  logic               collision,
   input  logic               reached_end,
   input  logic [9:0]         frog_y,
   output logic [1:0]         state,
   output logic               respawn,
   output logic [2:0]         lives,
   output logic [SCORE_W-1:0] score,
   output logic [3:0]         level,
   output logic [10:0]        time_left,
   output logic               game_over,
   output logic [SCORE_W-1:0] hiscore
);

   typedef enum logic [1:0] {
      MENU    = 2'd0,
      PLAYING = 2'd1,
      DEAD    = 2'd2,
      WIN     = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic               respawn_q, respawn_d;
   logic [2:0]         lives_q, lives_d;
   logic [SCORE_W-1:0] score_q, score_d;
   logic [3:0]         level_q, level_d;
   logic [10:0]        time_q, time_d;
   logic               game_over_q, game_over_d;
   logic [6:0]         fcnt_q, fcnt_d;
   logic [3:0]         best_row_q, best_row_d;

   logic [9:0]         row_full;
   logic [3:0]         row;
   logic [SCORE_W:0]   score_goal;
   logic [SCORE_W:0]   score_step;
   logic               timeout;

   // Grid row of the frog (clipped to 15) and saturating score adders
   always_comb begin
      row_full   = frog_y >> BLOCK_SHIFT;
      row        = (row_full > 10'd15) ? 4'd15 : row_full[3:0];
      score_goal = {1'b0, score_q} + (SCORE_W+1)'(GOAL_POINTS);
      score_step = {1'b0, score_q} + (SCORE_W+1)'(1);
      timeout    = frame_tick && (time_q == 11'd1);
   end

`ifdef GAME_HISCORE_EN
   logic [SCORE_W-1:0] hiscore_q, hiscore_d;
`endif

   // Next-state and output computation for the game sequencer
   always_comb begin
      state_d     = state_q;
      respawn_d   = 1'b0;
      lives_d     = lives_q;
      score_d     = score_q;
      level_d     = level_q;
      time_d      = time_q;
      game_over_d = game_over_q;
      fcnt_d      = fcnt_q;
      best_row_d  = best_row_q;
`ifdef GAME_HISCORE_EN
      hiscore_d   = hiscore_q;
`endif
      case (state_q)
         MENU: begin
            if (start_tick) begin
               state_d    = PLAYING;
               lives_d    = 3'(LIVES_INIT);
               score_d    = '0;
               level_d    = 4'd1;
               time_d     = 11'(ROUND_FRAMES);
               best_row_d = 4'd15;
               respawn_d  = 1'b1;
            end
         end
         PLAYING: begin
            if (collision || timeout) begin
               // Timeout lets the timer land on 0; a plain collision leaves it untouched
               state_d     = DEAD;
               fcnt_d      = '0;
               lives_d     = lives_q - 3'd1;
               game_over_d = (lives_q == 3'd1);
               if (timeout) time_d = '0;
            end else if (reached_end) begin
               state_d = WIN;
               fcnt_d  = '0;
               score_d = score_goal[SCORE_W] ? '1 : score_goal[SCORE_W-1:0];
               level_d = (level_q == 4'd15) ? 4'd15 : level_q + 4'd1;
            end else begin
               if (row < best_row_q) begin
                  best_row_d = row;
                  score_d    = score_step[SCORE_W] ? '1 : score_step[SCORE_W-1:0];
               end
               if (frame_tick) time_d = time_q - 11'd1;
            end
         end
         DEAD: begin
            if (frame_tick) begin
               if (fcnt_q == 7'(DEAD_FRAMES - 1)) begin
                  fcnt_d = '0;
                  if (lives_q != 3'd0) begin
                     state_d    = PLAYING;
                     respawn_d  = 1'b1;
                     time_d     = 11'(ROUND_FRAMES);
                     best_row_d = 4'd15;
                  end else begin
                     state_d     = MENU;
                     game_over_d = 1'b0;
`ifdef GAME_HISCORE_EN
                     if (score_q > hiscore_q) hiscore_d = score_q;
`endif
                  end
               end else begin
                  fcnt_d = fcnt_q + 7'd1;
               end
            end
         end
         WIN: begin
            if (frame_tick) begin
               if (fcnt_q == 7'(WIN_FRAMES - 1)) begin
                  fcnt_d     = '0;
                  state_d    = PLAYING;
                  respawn_d  = 1'b1;
                  time_d     = 11'(ROUND_FRAMES);
                  best_row_d = 4'd15;
               end else begin
                  fcnt_d = fcnt_q + 7'd1;
               end
            end
         end
         default: state_d = MENU;
      endcase
   end

   // State and datapath registers, cleared asynchronously by reset
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= MENU;
         respawn_q   <= 1'b0;
         lives_q     <= '0;
         score_q     <= '0;
         level_q     <= 4'd1;
         time_q      <= 11'(ROUND_FRAMES);
         game_over_q <= 1'b0;
         fcnt_q      <= '0;
         best_row_q  <= 4'd15;
      end else begin
         state_q     <= state_d;
         respawn_q   <= respawn_d;
         lives_q     <= lives_d;
         score_q     <= score_d;
         level_q     <= level_d;
         time_q      <= time_d;
         game_over_q <= game_over_d;
         fcnt_q      <= fcnt_d;
         best_row_q  <= best_row_d;
      end
   end

`ifdef GAME_HISCORE_EN
   // Best score register; survives new games, cleared only by reset
   always_ff @(posedge clk or posedge reset) begin
      if (reset) hiscore_q <= '0;
      else       hiscore_q <= hiscore_d;
   end
   assign hiscore = hiscore_q;
`else
   assign hiscore = '0;
`endif

   assign state     = state_q;
   assign respawn   = respawn_q;
   assign lives     = lives_q;
   assign score     = score_q;
   assign level     = level_q;
   assign time_left = time_q;
   assign game_over = game_over_q;

endmodule
